timestamp_rtc: RTL and testbench

- Parametrised successor to the free-running nanosecond counter: a real-time clock that keeps seconds and nanoseconds as separate registers, with no division or modulo.
- Adds a fixed-point (fractional-ns) clock period, software time set, rate trim, a PPS pulse and N independent capture channels.
- Capture channels latch the time on packet-start strobes from the capture path, for per-packet timestamps in pcap records.

---
 rtl/timestamp_pkg.sv | 20 ++
 rtl/timestamp_rtc_if.sv | 39 +++
 rtl/ts_capture_channel.sv | 64 ++++++
 rtl/timestamp_rtc.sv | 111 +++++++++++
 tb/tb_timestamp_rtc.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/timestamp_pkg.sv
// Shared constants, timestamp type and period helper for the timestamp RTC.
package timestamp_pkg;

  localparam logic [31:0] NS_PER_SEC   = 32'd1_000_000_000;
  localparam int          NS_WIDTH     = 30;
  localparam int          TS_SEC_WIDTH = 32;

  typedef struct packed {
    logic [TS_SEC_WIDTH-1:0] sec;
    logic [NS_WIDTH-1:0]     ns;
  } ts_t;

  // Nominal per-cycle increment as an unsigned fixed-point value with fracBits fraction bits.
  function automatic logic [63:0] defaultInc(input int unsigned periodNs,
                                             input int unsigned periodFrac,
                                             input int unsigned fracBits);
    return (64'(periodNs) << fracBits) + 64'(periodFrac);
  endfunction

endpackage

// File: rtl/timestamp_rtc_if.sv
// Bus bundle for the timestamp RTC: time set, rate trim, time outputs and capture channels.
interface timestamp_rtc_if #(
  parameter int SEC_WIDTH   = 32,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_CAPTURE = 2
);
  import timestamp_pkg::*;

  logic                                       set_valid;
  logic [SEC_WIDTH-1:0]                       set_seconds;
  logic [NS_WIDTH-1:0]                        set_nanoseconds;
  logic                                       set_error;
  logic                                       rate_adj_valid;
  logic [FRAC_BITS-1:0]                       rate_adj;
  logic [SEC_WIDTH-1:0]                       seconds;
  logic [NS_WIDTH-1:0]                        nanoseconds;
  logic                                       pps;
  logic [NUM_CAPTURE-1:0]                     capture_strobe;
  logic [NUM_CAPTURE-1:0]                     capture_ack;
  logic [NUM_CAPTURE-1:0]                     capture_valid;
  logic [NUM_CAPTURE-1:0]                     capture_overrun;
  logic [NUM_CAPTURE-1:0][SEC_WIDTH-1:0]      capture_seconds;
  logic [NUM_CAPTURE-1:0][NS_WIDTH-1:0]       capture_nanoseconds;

  modport master (
    output set_valid, set_seconds, set_nanoseconds, rate_adj_valid, rate_adj,
           capture_strobe, capture_ack,
    input  set_error, seconds, nanoseconds, pps, capture_valid, capture_overrun,
           capture_seconds, capture_nanoseconds
  );

  modport slave (
    input  set_valid, set_seconds, set_nanoseconds, rate_adj_valid, rate_adj,
           capture_strobe, capture_ack,
    output set_error, seconds, nanoseconds, pps, capture_valid, capture_overrun,
           capture_seconds, capture_nanoseconds
  );

endinterface

// File: rtl/ts_capture_channel.sv
// One timestamp capture slot: latches the visible time on strobe, holds it until acked.
module ts_capture_channel
  import timestamp_pkg::*;
#(
  parameter int SEC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe_i,
  input  logic                 ack_i,
  input  logic [SEC_WIDTH-1:0] secNow_i,
  input  logic [NS_WIDTH-1:0]  nsNow_i,
  output logic                 valid_o,
  output logic                 overrun_o,
  output logic [SEC_WIDTH-1:0] sec_o,
  output logic [NS_WIDTH-1:0]  ns_o
);

  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic [SEC_WIDTH-1:0] sec_q, sec_d;
  logic [NS_WIDTH-1:0]  ns_q, ns_d;

  // A strobe always wins; an ack in the same cycle only suppresses the overrun flag.
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    sec_d     = sec_q;
    ns_d      = ns_q;
    if (strobe_i) begin
      valid_d = 1'b1;
      sec_d   = secNow_i;
      ns_d    = nsNow_i;
      if (valid_q && !ack_i) begin
        overrun_d = 1'b1;
      end else if (valid_q && ack_i) begin
        overrun_d = 1'b0;
      end
    end else if (ack_i && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sec_q     <= '0;
      ns_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      sec_q     <= sec_d;
      ns_q      <= ns_d;
    end
  end

  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign sec_o     = sec_q;
  assign ns_o      = ns_q;

endmodule

// File: rtl/timestamp_rtc.sv
// Seconds/nanoseconds real-time clock with fractional period, rate trim, PPS and capture channels.
module timestamp_rtc
  import timestamp_pkg::*;
#(
  parameter int PERIOD_NS   = 20,
  parameter int PERIOD_FRAC = 0,
  parameter int FRAC_BITS   = 16,
  parameter int NUM_CAPTURE = 2,
  parameter int SEC_WIDTH   = 32
) (
  input logic clk,
  input logic reset,
  timestamp_rtc_if.slave bus
);

  localparam int INC_W = NS_WIDTH + FRAC_BITS;
  localparam logic [INC_W-1:0] BASE_INC =
    INC_W'(defaultInc(PERIOD_NS, PERIOD_FRAC, FRAC_BITS));

  logic [SEC_WIDTH-1:0] sec_q, sec_d;
  logic [NS_WIDTH-1:0]  ns_q, ns_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [FRAC_BITS-1:0] rateAdj_q, rateAdj_d;
  logic                 pps_q, pps_d;
  logic                 setError_q, setError_d;

  logic [INC_W-1:0]     incEff;
  logic [FRAC_BITS:0]   fracSum;
  logic [31:0]          nsSum;
  logic                 setOk;

  // The trim is signed, so it is sign-extended across the integer ns bits.
  assign incEff  = BASE_INC + {{NS_WIDTH{rateAdj_q[FRAC_BITS-1]}}, rateAdj_q};
  assign fracSum = {1'b0, frac_q} + {1'b0, incEff[FRAC_BITS-1:0]};
  assign nsSum   = {2'b00, ns_q} + {2'b00, incEff[INC_W-1:FRAC_BITS]} + 32'(fracSum[FRAC_BITS]);
  assign setOk   = bus.set_valid && ({2'b00, bus.set_nanoseconds} < NS_PER_SEC);

  // One conditional subtraction handles the rollover because the increment is below one second.
  always_comb begin
    sec_d      = sec_q;
    ns_d       = ns_q;
    frac_d     = frac_q;
    pps_d      = 1'b0;
    setError_d = 1'b0;
    rateAdj_d  = bus.rate_adj_valid ? bus.rate_adj : rateAdj_q;
    if (setOk) begin
      sec_d  = bus.set_seconds;
      ns_d   = bus.set_nanoseconds;
      frac_d = '0;
    end else begin
      setError_d = bus.set_valid;
      frac_d     = fracSum[FRAC_BITS-1:0];
      if (nsSum >= NS_PER_SEC) begin
        ns_d  = NS_WIDTH'(nsSum - NS_PER_SEC);
        sec_d = sec_q + 1'b1;
        pps_d = 1'b1;
      end else begin
        ns_d = NS_WIDTH'(nsSum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q      <= '0;
      ns_q       <= '0;
      frac_q     <= '0;
      rateAdj_q  <= '0;
      pps_q      <= 1'b0;
      setError_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      ns_q       <= ns_d;
      frac_q     <= frac_d;
      rateAdj_q  <= rateAdj_d;
      pps_q      <= pps_d;
      setError_q <= setError_d;
    end
  end

  assign bus.seconds     = sec_q;
  assign bus.nanoseconds = ns_q;
  assign bus.pps         = pps_q;
  assign bus.set_error   = setError_q;

  logic [NUM_CAPTURE-1:0]                capValid;
  logic [NUM_CAPTURE-1:0]                capOverrun;
  logic [NUM_CAPTURE-1:0][SEC_WIDTH-1:0] capSec;
  logic [NUM_CAPTURE-1:0][NS_WIDTH-1:0]  capNs;

  for (genvar g = 0; g < NUM_CAPTURE; g++) begin : gen_capture
    ts_capture_channel #(.SEC_WIDTH(SEC_WIDTH)) u_channel (
      .clk       (clk),
      .reset     (reset),
      .strobe_i  (bus.capture_strobe[g]),
      .ack_i     (bus.capture_ack[g]),
      .secNow_i  (sec_q),
      .nsNow_i   (ns_q),
      .valid_o   (capValid[g]),
      .overrun_o (capOverrun[g]),
      .sec_o     (capSec[g]),
      .ns_o      (capNs[g])
    );
  end

  assign bus.capture_valid       = capValid;
  assign bus.capture_overrun     = capOverrun;
  assign bus.capture_seconds     = capSec;
  assign bus.capture_nanoseconds = capNs;

endmodule

// File: tb/tb_timestamp_rtc.sv
// Scoreboard bench for timestamp_rtc: time kept as one fixed-point quantity, captures modelled per channel.
module tb_timestamp_rtc;
  import timestamp_pkg::*;

  localparam int     SW   = 32;
  localparam int     FB   = 16;
  localparam int     NC   = 2;
  localparam longint FINE_PER_SEC = 64'd1_000_000_000 << FB;
  localparam longint BASE_FINE    = 64'd20 << FB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timestamp_rtc_if #(.SEC_WIDTH(SW), .FRAC_BITS(FB), .NUM_CAPTURE(NC)) busA ();
  timestamp_rtc_if #(.SEC_WIDTH(SW), .FRAC_BITS(FB), .NUM_CAPTURE(NC)) busB ();

  timestamp_rtc #(.PERIOD_NS(20), .PERIOD_FRAC(0), .FRAC_BITS(FB),
                  .NUM_CAPTURE(NC), .SEC_WIDTH(SW)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave));

  timestamp_rtc #(.PERIOD_NS(6), .PERIOD_FRAC(16'h6667), .FRAC_BITS(FB),
                  .NUM_CAPTURE(NC), .SEC_WIDTH(SW)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave));

  typedef struct packed {
    ts_t                    now;
    logic                   pps;
    logic                   err;
    logic [NC-1:0]          valid;
    logic [NC-1:0]          over;
    logic [NC-1:0][SW-1:0]  capSec;
    logic [NC-1:0][29:0]    capNs;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Reference model: seconds plus one fixed-point "fine" time in 2^-16 ns units.
  longint unsigned        mSec;
  longint                 mFine;
  int                     mRate;
  logic                   mPps, mErr;
  logic [NC-1:0]          mValid, mOver;
  logic [NC-1:0][SW-1:0]  mCapSec;
  logic [NC-1:0][29:0]    mCapNs;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit setV, input logic [31:0] setS,
                               input logic [29:0] setN, input bit rateV, input logic [15:0] rate,
                               input logic [NC-1:0] strobe, input logic [NC-1:0] ack);
    exp_t e;
    longint unsigned curSec;
    longint          curNs;
    @(negedge clk);
    reset                    = rst;
    busA.set_valid           = setV;
    busA.set_seconds         = setS;
    busA.set_nanoseconds     = setN;
    busA.rate_adj_valid      = rateV;
    busA.rate_adj            = rate;
    busA.capture_strobe      = strobe;
    busA.capture_ack         = ack;
    if (rst) begin
      mSec = 0; mFine = 0; mRate = 0; mPps = 0; mErr = 0;
      mValid = '0; mOver = '0; mCapSec = '0; mCapNs = '0;
    end else begin
      curSec = mSec;
      curNs  = mFine >>> FB;
      for (int c = 0; c < NC; c++) begin
        if (strobe[c]) begin
          if (mValid[c]) mOver[c] = !ack[c];
          mValid[c]  = 1'b1;
          mCapSec[c] = SW'(curSec);
          mCapNs[c]  = 30'(curNs);
        end else if (ack[c] && mValid[c]) begin
          mValid[c] = 1'b0;
          mOver[c]  = 1'b0;
        end
      end
      mPps = 1'b0;
      mErr = 1'b0;
      if (setV && setN < 30'd1_000_000_000) begin
        mSec  = setS;
        mFine = longint'(setN) << FB;
      end else begin
        mErr  = setV;
        mFine = mFine + BASE_FINE + mRate;
        if (mFine >= FINE_PER_SEC) begin
          mFine = mFine - FINE_PER_SEC;
          mSec  = (mSec + 1) & 64'hFFFF_FFFF;
          mPps  = 1'b1;
        end
      end
      if (rateV) mRate = int'($signed(rate));
    end
    e.now.sec = SW'(mSec);
    e.now.ns  = 30'(mFine >>> FB);
    e.pps     = mPps;
    e.err     = mErr;
    e.valid   = mValid;
    e.over    = mOver;
    e.capSec  = mCapSec;
    e.capNs   = mCapNs;
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  // Monitor: the registered outputs settle after each rising edge; compare them there.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("seconds", busA.seconds, e.now.sec);
        checkOutput("nanoseconds", busA.nanoseconds, e.now.ns);
        checkOutput("pps", busA.pps, e.pps);
        checkOutput("set_error", busA.set_error, e.err);
        for (int c = 0; c < NC; c++) begin
          checkOutput($sformatf("cap%0d_valid", c), busA.capture_valid[c], e.valid[c]);
          checkOutput($sformatf("cap%0d_overrun", c), busA.capture_overrun[c], e.over[c]);
          if (e.valid[c]) begin
            checkOutput($sformatf("cap%0d_sec", c), busA.capture_seconds[c], e.capSec[c]);
            checkOutput($sformatf("cap%0d_ns", c), busA.capture_nanoseconds[c], e.capNs[c]);
          end
        end
      end
    end
  end

  initial begin
    busB.set_valid = 0; busB.set_seconds = '0; busB.set_nanoseconds = '0;
    busB.rate_adj_valid = 0; busB.rate_adj = '0;
    busB.capture_strobe = '0; busB.capture_ack = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, 0, 0, '0, '0);

    // Fractional period 6 + 0x6667/65536 ns on the second instance.
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (i == 4 || i == 9) begin
        @(posedge clk);
        #1;
        checkOutput("frac_ns", busB.nanoseconds, (i == 4) ? 32 : 64);
      end
    end
    idle(40);

    // Set near the second boundary, then an out-of-range set.
    applyStimulus(0, 1, 5, 30'd999_999_990, 0, 0, '0, '0);
    idle(3);
    applyStimulus(0, 1, 7, 30'd1_000_000_000, 0, 0, '0, '0);
    idle(2);

    // Channel 0 capture, overwrite without ack, then ack.
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, '0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, '0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, '0, 2'b01);
    applyStimulus(0, 0, 0, 0, 0, 0, '0, 2'b01);

    // Set coinciding with a channel 1 strobe, then strobe+ack on a valid channel 0.
    applyStimulus(0, 1, 9, 0, 0, 0, 2'b10, '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 2'b01);
    idle(1);

    // Rate trim, seconds wrap, then reset with a capture pending.
    applyStimulus(0, 0, 0, 0, 1, 16'h8000, '0, '0);
    idle(6);
    applyStimulus(0, 0, 0, 0, 1, 16'h4000, '0, '0);
    idle(4);
    applyStimulus(0, 1, 32'hFFFF_FFFF, 30'd999_999_970, 0, 0, '0, '0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b11, '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, '0);
    applyStimulus(1, 0, 0, 0, 0, 0, '0, '0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rst, setV, rateV;
      logic [31:0] setS;
      logic [29:0] setN;
      logic [15:0] rate;
      logic [NC-1:0] strobe, ack;
      rst   = ($urandom_range(0, 499) == 0);
      setV  = ($urandom_range(0, 49) == 0);
      rateV = ($urandom_range(0, 39) == 0);
      setS  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(0, 3))
        0:       setN = 30'(1_000_000_000 + $urandom_range(0, 99));
        1:       setN = 30'($urandom_range(0, 999_999_999));
        default: setN = 30'(999_999_800 + $urandom_range(0, 199));
      endcase
      rate = 16'($urandom);
      for (int c = 0; c < NC; c++) begin
        strobe[c] = ($urandom_range(0, 3) == 0);
        ack[c]    = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(rst, setV, setS, setN, rateV, rate, strobe, ack);
    end
    idle(2);
    @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      checkOutput("queue_drained", expQ.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
